// File: rtl/frame_buffer_swapper_if.sv
// Bundles the drawing-side, scan-out and status signals of frame_buffer_swapper.
// master: drawing manager / display side; slave: the frame store.
interface frame_buffer_swapper_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 12
);
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  frame_done;
   logic                  draw_start;
   logic                  draw_ack;
   logic                  buffer_select;
   logic                  vblank;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [DATA_WIDTH-1:0] read_data;
   logic [15:0]           frame_count;
   logic [15:0]           late_count;

   modport master (
      output write_en, write_addr, write_data, frame_done, vblank, read_addr,
      input  draw_start, draw_ack, buffer_select, read_data, frame_count, late_count
   );

   modport slave (
      input  write_en, write_addr, write_data, frame_done, vblank, read_addr,
      output draw_start, draw_ack, buffer_select, read_data, frame_count, late_count
   );
endinterface

// File: rtl/frame_buffer_swapper.sv
// Double-buffered frame store: pixel writes land in the back buffer, scan-out
// reads the front buffer, and the two are exchanged only at vblank after a finished frame.
module frame_buffer_swapper #(
   parameter int BUFFER_WIDTH      = 160,
   parameter int BUFFER_HEIGHT     = 120,
   parameter int BUFFER_DATA_WIDTH = 12,
   parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT)
) (
   input logic                   clk,
   input logic                   rstn,
   frame_buffer_swapper_if.slave bus
);
   localparam int unsigned DEPTH = BUFFER_WIDTH * BUFFER_HEIGHT;

   localparam logic [1:0] START       = 2'd0;
   localparam logic [1:0] DRAWING     = 2'd1;
   localparam logic [1:0] WAIT_VBLANK = 2'd2;

   logic [1:0]                   state;
   logic                         front_sel;
   logic                         draw_start;
   logic                         draw_ack;
   logic [15:0]                  frame_count;
   logic [15:0]                  late_count;

   logic [BUFFER_DATA_WIDTH-1:0] mem0 [DEPTH];
   logic [BUFFER_DATA_WIDTH-1:0] mem1 [DEPTH];
   logic [BUFFER_DATA_WIDTH-1:0] rd0;
   logic [BUFFER_DATA_WIDTH-1:0] rd1;
   logic                         rd_sel;
   logic                         rd_valid;

   logic                         write_ok;
   logic                         read_ok;
   logic                         frame_seen;
   logic                         swap;

   assign write_ok = bus.write_en && (32'(bus.write_addr) < DEPTH);
   assign read_ok  = 32'(bus.read_addr) < DEPTH;

   // A frame_done still held during the ack cycle belongs to the frame just swapped.
   assign frame_seen = bus.frame_done && !draw_ack;

   always_comb begin
      swap = 1'b0;
      case (state)
         DRAWING:     swap = frame_seen && bus.vblank;
         WAIT_VBLANK: swap = bus.vblank;
         default:     swap = 1'b0;
      endcase
   end

   // Each array gets its own unreset write/read port so both map onto block RAM.
   always_ff @(posedge clk) begin
      if (write_ok && front_sel) mem0[bus.write_addr] <= bus.write_data;
      rd0 <= mem0[bus.read_addr];
   end

   always_ff @(posedge clk) begin
      if (write_ok && !front_sel) mem1[bus.write_addr] <= bus.write_data;
      rd1 <= mem1[bus.read_addr];
   end

   // Which array and whether the address was in range travel alongside the RAM read.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_sel   <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         rd_sel   <= front_sel;
         rd_valid <= read_ok;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= START;
         front_sel   <= 1'b0;
         draw_start  <= 1'b0;
         draw_ack    <= 1'b0;
         frame_count <= '0;
         late_count  <= '0;
      end else begin
         draw_start <= 1'b0;
         draw_ack   <= swap;
         if (swap) begin
            front_sel   <= ~front_sel;
            frame_count <= frame_count + 16'd1;
         end
         case (state)
            START: begin
               draw_start <= 1'b1;
               state      <= DRAWING;
            end
            DRAWING: begin
               if (frame_seen && !bus.vblank) begin
                  state <= WAIT_VBLANK;
               end else if (bus.vblank && !frame_seen && late_count != 16'hFFFF) begin
                  late_count <= late_count + 16'd1;
               end
            end
            WAIT_VBLANK: begin
               if (bus.vblank) state <= DRAWING;
            end
            default: state <= START;
         endcase
      end
   end

   assign bus.draw_start    = draw_start;
   assign bus.draw_ack      = draw_ack;
   assign bus.buffer_select = ~front_sel;
   assign bus.frame_count   = frame_count;
   assign bus.late_count    = late_count;
   assign bus.read_data     = rd_valid ? (rd_sel ? rd1 : rd0) : '0;
endmodule

// File: tb/tb_frame_buffer_swapper.sv
// Scoreboard bench for frame_buffer_swapper: a frame-level reference model queues the
// expected outputs of every cycle and a negedge monitor compares them against the DUT.
module tb_frame_buffer_swapper;
   localparam int AW    = 15;
   localparam int DW    = 12;
   localparam int DEPTH = 160 * 120;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   frame_buffer_swapper_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   frame_buffer_swapper #(
      .BUFFER_WIDTH(160),
      .BUFFER_HEIGHT(120),
      .BUFFER_DATA_WIDTH(DW),
      .BUFFER_ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   typedef struct {
      bit          start;
      bit          ack;
      bit          bsel;
      bit [15:0]   fc;
      bit [15:0]   lc;
      bit          rd_chk;
      logic [DW-1:0] rd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: which buffer is on screen, whether a finished frame awaits vblank,
   // and the pixels known to be in each buffer.
   bit          m_front;
   bit          m_pending;
   bit          m_started;
   bit          m_ack;
   bit [15:0]   m_fc;
   bit [15:0]   m_lc;
   logic [DW-1:0] m_mem [2][DEPTH];
   bit          m_vld [2][DEPTH];

   function automatic exp_t reset_exp();
      exp_t e;
      e.start = 1'b0; e.ack = 1'b0; e.bsel = 1'b1;
      e.fc = '0; e.lc = '0; e.rd_chk = 1'b1; e.rd = '0;
      return e;
   endfunction

   function automatic void chk(string name, logic [15:0] act, logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endfunction

   task automatic tick();
      exp_t e;
      bit   swap;
      int   ra;
      int   wa;
      swap = 1'b0;
      ra = int'(bus.read_addr);
      wa = int'(bus.write_addr);
      if (!rstn) begin
         m_front = 1'b0; m_pending = 1'b0; m_started = 1'b0; m_ack = 1'b0;
         m_fc = '0; m_lc = '0;
         e = reset_exp();
      end else begin
         e.start  = !m_started;
         e.rd_chk = 1'b1;
         e.rd     = '0;
         if (ra < DEPTH) begin
            e.rd_chk = m_vld[m_front][ra];
            e.rd     = m_mem[m_front][ra];
         end
         if (bus.write_en && wa < DEPTH) begin
            m_mem[m_front ^ 1'b1][wa] = bus.write_data;
            m_vld[m_front ^ 1'b1][wa] = 1'b1;
         end
         if (m_started) begin
            bit fd_now;
            fd_now = bus.frame_done && !m_ack;
            if (bus.vblank && (m_pending || fd_now)) swap = 1'b1;
            else if (!m_pending && fd_now) m_pending = 1'b1;
            else if (!m_pending && bus.vblank && m_lc != 16'hFFFF) m_lc++;
         end
         m_started = 1'b1;
         if (swap) begin
            m_front   = ~m_front;
            m_fc++;
            m_pending = 1'b0;
         end
         m_ack   = swap;
         e.ack   = swap;
         e.bsel  = ~m_front;
         e.fc    = m_fc;
         e.lc    = m_lc;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Reset is asynchronous: the outputs of the cycle already queued clear immediately.
   task automatic assert_reset();
      rstn = 1'b0;
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = reset_exp();
   endtask

   task automatic wr(int a, logic [DW-1:0] d);
      bus.write_en   = 1'b1;
      bus.write_addr = AW'(a);
      bus.write_data = d;
      tick();
      bus.write_en   = 1'b0;
   endtask

   task automatic do_swap();
      bus.frame_done = 1'b1;
      repeat (2) tick();
      bus.vblank = 1'b1;
      tick();
      bus.vblank = 1'b0;
      bus.frame_done = 1'b0;
      tick();
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("draw_start",    16'(bus.draw_start),    16'(e.start));
            chk("draw_ack",      16'(bus.draw_ack),      16'(e.ack));
            chk("buffer_select", 16'(bus.buffer_select), 16'(e.bsel));
            chk("frame_count",   bus.frame_count,        e.fc);
            chk("late_count",    bus.late_count,         e.lc);
            if (e.rd_chk) chk("read_data", 16'(bus.read_data), 16'(e.rd));
         end
      end
   end

   initial begin
      rstn = 1'b0;
      bus.write_en = 1'b0; bus.write_addr = '0; bus.write_data = '0;
      bus.frame_done = 1'b0; bus.vblank = 1'b0; bus.read_addr = '0;
      repeat (3) tick();
      rstn = 1'b1;
      repeat (3) tick();

      // Write isolation: 0x123 becomes visible, then 0xABC stays hidden until the next swap.
      bus.read_addr = AW'(5);
      wr(5, 12'h123);
      do_swap();
      wr(5, 12'hABC);
      repeat (3) tick();
      do_swap();
      repeat (2) tick();

      // Late frames
      repeat (3) begin
         bus.vblank = 1'b1;
         tick();
         bus.vblank = 1'b0;
         repeat (4) tick();
      end

      // Coincident frame_done and vblank
      bus.frame_done = 1'b1;
      bus.vblank = 1'b1;
      tick();
      bus.vblank = 1'b0;
      bus.frame_done = 1'b0;
      repeat (3) tick();

      // frame_done held long after the swap, no further vblank
      bus.frame_done = 1'b1;
      repeat (2) tick();
      bus.vblank = 1'b1;
      tick();
      bus.vblank = 1'b0;
      repeat (10) tick();
      bus.frame_done = 1'b0;
      repeat (2) tick();

      // Out-of-range write and read
      wr(DEPTH, 12'hFFF);
      wr(32767, 12'h5A5);
      bus.read_addr = AW'(DEPTH);
      repeat (2) tick();
      bus.read_addr = AW'(32767);
      repeat (2) tick();
      bus.read_addr = AW'(5);
      repeat (2) tick();

      // Reset while waiting for vblank after two swaps
      bus.vblank = 1'b1;
      tick();
      bus.vblank = 1'b0;
      tick();
      do_swap();
      bus.frame_done = 1'b1;
      repeat (2) tick();
      assert_reset();
      bus.frame_done = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      repeat (4) tick();

      // Random traffic over a small window so reads often hit known pixels
      for (int i = 0; i < 3000; i++) begin
         bus.write_en   = 1'($urandom_range(0, 1));
         bus.write_addr = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH, 32767))
                                                       : AW'($urandom_range(0, 63));
         bus.write_data = DW'($urandom);
         bus.read_addr  = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH, 32767))
                                                       : AW'($urandom_range(0, 63));
         bus.vblank     = ($urandom_range(0, 19) == 0);
         if (m_ack) bus.frame_done = 1'b0;
         else if ($urandom_range(0, 9) == 0) bus.frame_done = 1'b1;
         tick();
      end

      bus.write_en = 1'b0; bus.vblank = 1'b0; bus.frame_done = 1'b0;
      repeat (2) tick();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
